branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 149 ++++++++++++++
 tb/tb_branch_predictor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Two-slot BTB branch predictor with 2-bit counters and mispredict redirect.
// Optional: define BP_PERF_CNT_EN to build the branch/mispredict counters.
module branch_predictor #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] pcf_i,
    input  logic [WIDTH-1:0] pcf2_i,
    output logic             pc_predict_redirect_o,
    output logic [WIDTH-1:0] predicted_target_pc_o,
    output logic             pred_taken0_o,
    output logic             pred_taken1_o,
    input  logic             resolve_valid_i,
    input  logic [WIDTH-1:0] resolve_pc_i,
    input  logic [WIDTH-1:0] resolve_target_i,
    input  logic [WIDTH-1:0] resolve_pred_target_i,
    input  logic             resolve_taken_i,
    input  logic             resolve_pred_taken_i,
    output logic             pc_redirect_o,
    output logic [WIDTH-1:0] mispredict_target_pc_o,
    output logic [31:0]      branch_cnt_o,
    output logic [31:0]      mispredict_cnt_o
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = WIDTH - IDX - 2;

    logic             valid_q [ENTRIES];
    logic [TW-1:0]    tag_q   [ENTRIES];
    logic [WIDTH-1:0] tgt_q   [ENTRIES];
    logic [1:0]       cnt_q   [ENTRIES];

    logic             redirect_q, redirect_d;
    logic [WIDTH-1:0] mtgt_q, mtgt_d;

    logic [IDX-1:0]   idx0, idx1, ridx;
    logic [TW-1:0]    tag0, tag1, rtag;
    logic             hit0, hit1, tk0, tk1, active;
    logic             rhit, accept, mispredict;
    logic [1:0]       cnt_nxt;

    logic unused_ok;
    assign unused_ok = ^{pcf_i[1:0], pcf2_i[1:0]};

    assign idx0 = pcf_i[IDX+1:2];
    assign tag0 = pcf_i[WIDTH-1:IDX+2];
    assign idx1 = pcf2_i[IDX+1:2];
    assign tag1 = pcf2_i[WIDTH-1:IDX+2];
    assign ridx = resolve_pc_i[IDX+1:2];
    assign rtag = resolve_pc_i[WIDTH-1:IDX+2];

    // A pending redirect is dropped immediately when reset is raised.
    assign pc_redirect_o          = redirect_q & ~rst;
    assign mispredict_target_pc_o = mtgt_q;

    // Fetch-side lookup; slot 0 wins, slot 1 is squashed behind a taken slot 0.
    always_comb begin
        hit0   = valid_q[idx0] && (tag_q[idx0] == tag0);
        hit1   = valid_q[idx1] && (tag_q[idx1] == tag1);
        tk0    = hit0 && cnt_q[idx0][1];
        tk1    = hit1 && cnt_q[idx1][1];
        active = en && !pc_redirect_o;
        pred_taken0_o         = active && tk0;
        pred_taken1_o         = active && !tk0 && tk1;
        pc_predict_redirect_o = active && (tk0 || tk1);
        predicted_target_pc_o = '0;
        if (pc_predict_redirect_o)
            predicted_target_pc_o = tk0 ? tgt_q[idx0] : tgt_q[idx1];
    end

    // Resolve-side detection; resolves during a redirect are wrong-path.
    always_comb begin
        accept     = resolve_valid_i && !pc_redirect_o;
        rhit       = valid_q[ridx] && (tag_q[ridx] == rtag);
        mispredict = accept &&
                     ((resolve_taken_i != resolve_pred_taken_i) ||
                      (resolve_taken_i &&
                       (resolve_target_i != resolve_pred_target_i)));
        cnt_nxt = cnt_q[ridx];
        if (resolve_taken_i) begin
            if (cnt_q[ridx] != 2'b11) cnt_nxt = cnt_q[ridx] + 2'b01;
        end else begin
            if (cnt_q[ridx] != 2'b00) cnt_nxt = cnt_q[ridx] - 2'b01;
        end
        redirect_d = mispredict;
        mtgt_d     = mtgt_q;
        if (mispredict)
            mtgt_d = resolve_taken_i ? resolve_target_i
                                     : resolve_pc_i + WIDTH'(4);
    end

    // Redirect pulse and corrected PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_q <= 1'b0;
            mtgt_q     <= '0;
        end else begin
            redirect_q <= redirect_d;
            mtgt_q     <= mtgt_d;
        end
    end

    // BTB update: train on hits, allocate only on taken misses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= 2'b01;
            end
        end else if (accept) begin
            if (rhit) begin
                cnt_q[ridx] <= cnt_nxt;
                if (resolve_taken_i) tgt_q[ridx] <= resolve_target_i;
            end else if (resolve_taken_i) begin
                valid_q[ridx] <= 1'b1;
                tag_q[ridx]   <= rtag;
                tgt_q[ridx]   <= resolve_target_i;
                cnt_q[ridx]   <= 2'b10;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] bcnt_q, mcnt_q;

    // Accepted-resolve and mispredict event counters, free-running wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            if (accept)     bcnt_q <= bcnt_q + 32'd1;
            if (mispredict) mcnt_q <= mcnt_q + 32'd1;
        end
    end

    assign branch_cnt_o     = bcnt_q;
    assign mispredict_cnt_o = mcnt_q;
`else
    assign branch_cnt_o     = '0;
    assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor.
module tb_branch_predictor;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [W-1:0] pcf, pcf2;
    logic         pred_redir;
    logic [W-1:0] pred_tgt;
    logic         pt0, pt1;
    logic         rv;
    logic [W-1:0] rpc, rtgt, rptgt;
    logic         rtk, rptk;
    logic         redir;
    logic [W-1:0] mtgt;
    logic [31:0]  bcnt, mcnt;

    int checks = 0;
    int errors = 0;

    typedef enum int {S_PR, S_PT, S_P0, S_P1, S_MR, S_MT, S_BC, S_MC} sel_t;
    typedef struct {
        sel_t        sel;
        logic [31:0] val;
        string       tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    branch_predictor #(.WIDTH(W), .ENTRIES(16)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .en                    (en),
        .pcf_i                 (pcf),
        .pcf2_i                (pcf2),
        .pc_predict_redirect_o (pred_redir),
        .predicted_target_pc_o (pred_tgt),
        .pred_taken0_o         (pt0),
        .pred_taken1_o         (pt1),
        .resolve_valid_i       (rv),
        .resolve_pc_i          (rpc),
        .resolve_target_i      (rtgt),
        .resolve_pred_target_i (rptgt),
        .resolve_taken_i       (rtk),
        .resolve_pred_taken_i  (rptk),
        .pc_redirect_o         (redir),
        .mispredict_target_pc_o(mtgt),
        .branch_cnt_o          (bcnt),
        .mispredict_cnt_o      (mcnt)
    );

    task automatic push(input sel_t s, input logic [31:0] v, input string t);
        exp_t e;
        e.sel = s;
        e.val = v;
        e.tag = t;
        sb.push_back(e);
    endtask

    task automatic push_pred(input logic r, input logic [31:0] t,
                             input logic p0, input logic p1, input string n);
        push(S_PR, {31'd0, r}, {n, ".redir"});
        push(S_PT, t, {n, ".tgt"});
        push(S_P0, {31'd0, p0}, {n, ".pt0"});
        push(S_P1, {31'd0, p1}, {n, ".pt1"});
    endtask

    task automatic push_cnt(input int b, input int m, input string n);
`ifdef BP_PERF_CNT_EN
        push(S_BC, b, {n, ".bcnt"});
        push(S_MC, m, {n, ".mcnt"});
`else
        push(S_BC, 32'd0, {n, ".bcnt"});
        push(S_MC, 32'd0, {n, ".mcnt"});
`endif
    endtask

    task automatic chk();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_PR:    obs = {31'd0, pred_redir};
                S_PT:    obs = pred_tgt;
                S_P0:    obs = {31'd0, pt0};
                S_P1:    obs = {31'd0, pt1};
                S_MR:    obs = {31'd0, redir};
                S_MT:    obs = mtgt;
                S_BC:    obs = bcnt;
                default: obs = mcnt;
            endcase
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk,
                           input logic [31:0] tg, input logic ptk,
                           input logic [31:0] ptg);
        rv    = 1'b1;
        rpc   = pc;
        rtk   = tk;
        rtgt  = tg;
        rptk  = ptk;
        rptgt = ptg;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pcf = '0; pcf2 = '0;
        rv = 1'b0; rpc = '0; rtgt = '0; rptgt = '0; rtk = 1'b0; rptk = 1'b0;
        tick(); tick();
        rst = 1'b0;
        push(S_MR, 0, "rst.mr");
        push(S_MT, 0, "rst.mt");
        push_cnt(0, 0, "rst");
        chk();

        pcf = 32'h40; pcf2 = 32'h44; en = 1'b1;
        push_pred(0, 0, 0, 0, "s1");
        chk();

        resolve(32'h40, 1, 32'h100, 0, 32'h0);
        push_pred(0, 0, 0, 0, "s2.nobypass");
        chk();
        tick();
        rv = 1'b0;
        push(S_MR, 1, "s2.mr");
        push(S_MT, 32'h100, "s2.mt");
        push_pred(0, 0, 0, 0, "s2.squash");
        chk();
        tick();
        push(S_MR, 0, "s2.pulse");
        push_pred(1, 32'h100, 1, 0, "s2.hit");
        push_cnt(1, 1, "s2");
        chk();

        resolve(32'h40, 0, 32'h0, 1, 32'h100);
        tick();
        rv = 1'b0;
        push(S_MR, 1, "s3.mr");
        push(S_MT, 32'h44, "s3.mt");
        chk();
        tick();
        push_pred(0, 0, 0, 0, "s3.wnt");
        push_cnt(2, 2, "s3");
        chk();

        resolve(32'h40, 1, 32'h100, 0, 32'h0);
        tick(); rv = 1'b0; tick();
        resolve(32'h44, 1, 32'h200, 0, 32'h0);
        tick(); rv = 1'b0;
        push(S_MT, 32'h200, "s4.mt");
        chk();
        tick();
        push_pred(1, 32'h100, 1, 0, "s4.prio");
        push_cnt(4, 4, "s4");
        chk();
        pcf = 32'h48;
        push_pred(1, 32'h200, 0, 1, "s4.slot1");
        chk();
        pcf = 32'h40;

        resolve(32'h40, 1, 32'h100, 1, 32'h100);
        tick(); rv = 1'b0;
        push(S_MR, 0, "ok.mr");
        push_cnt(5, 4, "ok");
        chk();
        resolve(32'h40, 1, 32'h180, 1, 32'h100);
        tick(); rv = 1'b0;
        push(S_MR, 1, "tgt.mr");
        push(S_MT, 32'h180, "tgt.mt");
        chk();
        tick();
        push_pred(1, 32'h180, 1, 0, "tgt.hit");
        push_cnt(6, 5, "tgt");
        chk();

        pcf = 32'h80; pcf2 = 32'h84;
        push_pred(0, 0, 0, 0, "s5.alias");
        chk();
        pcf = 32'h40; en = 1'b0;
        push_pred(0, 0, 0, 0, "s5.stall");
        chk();
        en = 1'b1;

        resolve(32'h40, 0, 32'h0, 1, 32'h180);
        tick();
        resolve(32'h40, 1, 32'h300, 0, 32'h0);
        push(S_MR, 1, "s6.mr");
        push(S_MT, 32'h44, "s6.mt");
        chk();
        tick(); rv = 1'b0;
        push(S_MR, 0, "s6.ignored");
        push(S_MT, 32'h44, "s6.mthold");
        push_pred(1, 32'h180, 1, 0, "s6.noupd");
        push_cnt(7, 6, "s6");
        chk();

        resolve(32'h40, 0, 32'h0, 1, 32'h180);
        tick(); rv = 1'b0;
        rst = 1'b1;
        push(S_MR, 0, "s6.rstsup");
        chk();
        tick();
        rst = 1'b0;
        push(S_MR, 0, "s6.post");
        push(S_MT, 0, "s6.mtrst");
        push_pred(0, 0, 0, 0, "s6.cleared");
        push_cnt(0, 0, "s6.rst");
        chk();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
